id_ex_stage: RTL and testbench

ID/EX pipeline stage of the RV32I pipeline. It registers the decoded control bundle (main control outputs plus the 4-bit ALU control code) and the operand/immediate data from decode, and presents them to execute one cycle later. It also detects load-use hazards, which stall fetch/decode and insert a bubble, and it squashes the decode-stage instruction on a taken branch or jump.

---
 rtl/id_ex_stage_pkg.sv | 28 ++
 rtl/id_ex_stage_load_use_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types and defaults for the ID/EX stage: control bundle, bubble constant,
// datapath widths.
package id_ex_stage_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RADDR_DEF = 5;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       add_sel;
    logic       link;
    logic       lui;
    logic [1:0] branch;
    logic [3:0] alu_cnt;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Control is only meaningful for a valid slot; this also scrubs X on invalid slots.
  function automatic ctrl_t gate_ctrl(input logic valid, input ctrl_t c);
    return valid ? c : CTRL_NOP;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: a load sitting in EX whose destination is read by
// the valid instruction in decode. Destination x0 never creates a hazard.
module load_use_detect #(
  parameter int RADDR = 5
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [RADDR-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [RADDR-1:0] id_rs1,
  input  logic [RADDR-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  output logic             hazard
);

  logic load_in_ex;
  logic rs1_hit;
  logic rs2_hit;

  assign load_in_ex = ex_valid & ex_mem_read & (ex_rd != '0);
  assign rs1_hit    = id_rs1_used & (id_rs1 == ex_rd);
  assign rs2_hit    = id_rs2_used & (id_rs2 == ex_rd);
  assign hazard     = load_in_ex & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch squash.
// Optional performance counters are built when IDEX_PERF_EN is defined.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_alu_src,
  input  logic             id_mem_to_reg,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_add_sel,
  input  logic             id_link,
  input  logic             id_lui,
  input  logic [1:0]       id_branch,
  input  logic [3:0]       id_alu_cnt,
  input  logic [2:0]       id_funct3,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RADDR-1:0] id_rs1,
  input  logic [RADDR-1:0] id_rs2,
  input  logic [RADDR-1:0] id_rd,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_flush,
  output logic             stall_if_id,
  output logic             ex_valid,
  output logic             ex_alu_src,
  output logic             ex_mem_to_reg,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_add_sel,
  output logic             ex_link,
  output logic             ex_lui,
  output logic [1:0]       ex_branch,
  output logic [3:0]       ex_alu_cnt,
  output logic [2:0]       ex_funct3,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RADDR-1:0] ex_rs1,
  output logic [RADDR-1:0] ex_rs2,
  output logic [RADDR-1:0] ex_rd
`ifdef IDEX_PERF_EN
  ,
  output logic [31:0]      perf_bubbles,
  output logic [31:0]      perf_flushes
`endif
);

  ctrl_t            id_ctrl;
  logic             hazard;
  logic             bubble;

  logic             valid_q,    valid_d;
  ctrl_t            ctrl_q,     ctrl_d;
  logic [2:0]       funct3_q,   funct3_d;
  logic [XLEN-1:0]  pc_q,       pc_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  imm_q,      imm_d;
  logic [RADDR-1:0] rs1_q,      rs1_d;
  logic [RADDR-1:0] rs2_q,      rs2_d;
  logic [RADDR-1:0] rd_q,       rd_d;

  assign id_ctrl = '{
    alu_src:    id_alu_src,
    mem_to_reg: id_mem_to_reg,
    reg_write:  id_reg_write,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    add_sel:    id_add_sel,
    link:       id_link,
    lui:        id_lui,
    branch:     id_branch,
    alu_cnt:    id_alu_cnt
  };

  load_use_detect #(.RADDR(RADDR)) u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .hazard      (hazard)
  );

  // A flush redirects fetch, so upstream must not hold even if a hazard exists.
  assign stall_if_id = hazard & ~ex_flush;
  assign bubble      = ex_flush | hazard;

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    funct3_d   = funct3_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    if (bubble) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else begin
      valid_d    = id_valid;
      ctrl_d     = gate_ctrl(id_valid, id_ctrl);
      funct3_d   = id_funct3;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= CTRL_NOP;
      funct3_q   <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      funct3_q   <= funct3_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_add_sel    = ctrl_q.add_sel;
  assign ex_link       = ctrl_q.link;
  assign ex_lui        = ctrl_q.lui;
  assign ex_branch     = ctrl_q.branch;
  assign ex_alu_cnt    = ctrl_q.alu_cnt;
  assign ex_funct3     = funct3_q;
  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;

`ifdef IDEX_PERF_EN
  logic [31:0] bubbles_q, bubbles_d;
  logic [31:0] flushes_q, flushes_d;

  // A flush that coincides with a hazard is counted only as a flush.
  assign bubbles_d = stall_if_id ? bubbles_q + 32'd1 : bubbles_q;
  assign flushes_d = ex_flush    ? flushes_q + 32'd1 : flushes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubbles_q <= '0;
      flushes_q <= '0;
    end else begin
      bubbles_q <= bubbles_d;
      flushes_q <= flushes_d;
    end
  end

  assign perf_bubbles = bubbles_q;
  assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage against an instruction-level
// model of the EX slot; perf counters are checked when IDEX_PERF_EN is defined.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        add_sel;
    logic        link;
    logic        lui;
    logic [1:0]  branch;
    logic [3:0]  alu_cnt;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_used;
    logic        rs2_used;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read;
  logic        id_mem_write, id_add_sel, id_link, id_lui;
  logic [1:0]  id_branch;
  logic [3:0]  id_alu_cnt;
  logic [2:0]  id_funct3;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, ex_flush;
  logic        stall_if_id, ex_valid, ex_alu_src, ex_mem_to_reg, ex_reg_write;
  logic        ex_mem_read, ex_mem_write, ex_add_sel, ex_link, ex_lui;
  logic [1:0]  ex_branch;
  logic [3:0]  ex_alu_cnt;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
`ifdef IDEX_PERF_EN
  logic [31:0] perf_bubbles, perf_flushes;
`endif

  int     checks = 0;
  int     errors = 0;
  instr_t m_ex;
  int     exp_bubbles = 0;
  int     exp_flushes = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_add_sel(id_add_sel), .id_link(id_link),
    .id_lui(id_lui), .id_branch(id_branch), .id_alu_cnt(id_alu_cnt),
    .id_funct3(id_funct3), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_flush(ex_flush), .stall_if_id(stall_if_id),
    .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_add_sel(ex_add_sel), .ex_link(ex_link),
    .ex_lui(ex_lui), .ex_branch(ex_branch), .ex_alu_cnt(ex_alu_cnt),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd)
`ifdef IDEX_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic instr_t kill_ctrl(input instr_t i);
    instr_t r = i;
    r.valid = 1'b0; r.alu_src = 1'b0; r.mem_to_reg = 1'b0; r.reg_write = 1'b0;
    r.mem_read = 1'b0; r.mem_write = 1'b0; r.add_sel = 1'b0; r.link = 1'b0;
    r.lui = 1'b0; r.branch = 2'b00; r.alu_cnt = 4'b0000;
    return r;
  endfunction

  function automatic instr_t base(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t i = '0;
    i.valid = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.pc = $urandom; i.rs1_data = $urandom; i.rs2_data = $urandom; i.imm = $urandom;
    return i;
  endfunction

  function automatic instr_t mk_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t i = base(rd, rs1, rs2);
    i.reg_write = 1'b1; i.alu_cnt = 4'b0010; i.rs1_used = 1'b1; i.rs2_used = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_lw(input logic [4:0] rd, input logic [4:0] rs1);
    instr_t i = base(rd, rs1, 5'd0);
    i.alu_src = 1'b1; i.mem_to_reg = 1'b1; i.reg_write = 1'b1; i.mem_read = 1'b1;
    i.alu_cnt = 4'b0010; i.funct3 = 3'b010; i.rs1_used = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_sw(input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t i = base(5'd0, rs1, rs2);
    i.alu_src = 1'b1; i.mem_write = 1'b1; i.alu_cnt = 4'b0010; i.funct3 = 3'b010;
    i.rs1_used = 1'b1; i.rs2_used = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_rand();
    instr_t i = base(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    i.valid = ($urandom_range(0, 9) != 0);
    {i.alu_src, i.mem_to_reg, i.reg_write, i.mem_write, i.add_sel, i.link, i.lui} = 7'($urandom);
    i.mem_read = ($urandom_range(0, 2) == 0);
    i.branch = 2'($urandom); i.alu_cnt = 4'($urandom); i.funct3 = 3'($urandom);
    i.rs1_used = 1'($urandom); i.rs2_used = 1'($urandom);
    return i;
  endfunction

  // Reference hazard rule stated at instruction level: valid load in EX
  // writing a nonzero register that the valid decode instruction reads.
  function automatic logic model_hazard(input instr_t id);
    if (!(m_ex.valid && m_ex.mem_read && m_ex.rd != 5'd0 && id.valid)) return 1'b0;
    return (id.rs1_used && id.rs1 == m_ex.rd) || (id.rs2_used && id.rs2 == m_ex.rd);
  endfunction

  task automatic drive(input instr_t i, input logic flush);
    id_valid = i.valid; id_alu_src = i.alu_src; id_mem_to_reg = i.mem_to_reg;
    id_reg_write = i.reg_write; id_mem_read = i.mem_read; id_mem_write = i.mem_write;
    id_add_sel = i.add_sel; id_link = i.link; id_lui = i.lui; id_branch = i.branch;
    id_alu_cnt = i.alu_cnt; id_funct3 = i.funct3; id_pc = i.pc;
    id_rs1_data = i.rs1_data; id_rs2_data = i.rs2_data; id_imm = i.imm;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    id_rs1_used = i.rs1_used; id_rs2_used = i.rs2_used; ex_flush = flush;
  endtask

  task automatic check_ex(input string tag);
    check({tag, ":valid"}, 64'(ex_valid), 64'(m_ex.valid));
    check({tag, ":ctrl"},
          64'({ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_add_sel, ex_link, ex_lui, ex_branch, ex_alu_cnt}),
          64'({m_ex.alu_src, m_ex.mem_to_reg, m_ex.reg_write, m_ex.mem_read, m_ex.mem_write,
               m_ex.add_sel, m_ex.link, m_ex.lui, m_ex.branch, m_ex.alu_cnt}));
    check({tag, ":pc_imm"}, {ex_pc, ex_imm}, {m_ex.pc, m_ex.imm});
    check({tag, ":opdata"}, {ex_rs1_data, ex_rs2_data}, {m_ex.rs1_data, m_ex.rs2_data});
    check({tag, ":idx"}, 64'({ex_funct3, ex_rs1, ex_rs2, ex_rd}),
          64'({m_ex.funct3, m_ex.rs1, m_ex.rs2, m_ex.rd}));
`ifdef IDEX_PERF_EN
    check({tag, ":perf_bub"}, 64'(perf_bubbles), 64'(exp_bubbles));
    check({tag, ":perf_fl"}, 64'(perf_flushes), 64'(exp_flushes));
`endif
  endtask

  // One pipeline cycle: present decode, check stall, clock, update model, check EX.
  // exp_stall >= 0 additionally pins the stall to a directed value.
  task automatic step(input instr_t i, input logic flush, input string tag, input int exp_stall);
    logic hz;
    drive(i, flush);
    #1;
    hz = model_hazard(i);
    check({tag, ":stall"}, 64'(stall_if_id), 64'(hz & ~flush));
    if (exp_stall >= 0) check({tag, ":stall_dir"}, 64'(stall_if_id), 64'(exp_stall));
    @(posedge clk);
    if (flush || hz) begin
      m_ex = kill_ctrl(m_ex);
      if (flush) exp_flushes++;
      else exp_bubbles++;
    end else begin
      m_ex = i.valid ? i : kill_ctrl(i);
    end
    #1;
    check_ex(tag);
  endtask

  initial begin
    instr_t add_i, lw_i, nx;
    m_ex = '0;
    drive(mk_rand(), 1'b0);

    // Reset with random decode inputs
    repeat (3) begin
      @(posedge clk);
      drive(mk_rand(), 1'($urandom));
      #1;
      check("reset:stall", 64'(stall_if_id), 64'd0);
      check_ex("reset");
    end
    rst_n = 1'b1;

    add_i = mk_add(5'd3, 5'd1, 5'd2);
    step(add_i, 1'b0, "add", 0);
    check("add:alu_cnt", 64'(ex_alu_cnt), 64'h2);
    check("add:reg_write", 64'(ex_reg_write), 64'd1);

    // Load-use: one bubble, then the consumer in EX
    step(mk_lw(5'd5, 5'd1), 1'b0, "lw5", 0);
    add_i = mk_add(5'd6, 5'd5, 5'd2);
    step(add_i, 1'b0, "lu_stall", 1);
    check("lu_stall:bubble", 64'(ex_valid), 64'd0);
    step(add_i, 1'b0, "lu_go", 0);
    check("lu_go:rs1", 64'(ex_rs1), 64'd5);

    // rd = x0 never stalls
    step(mk_lw(5'd0, 5'd1), 1'b0, "lw0", 0);
    step(mk_add(5'd6, 5'd0, 5'd2), 1'b0, "rd0", 0);
    check("rd0:valid", 64'(ex_valid), 64'd1);

    // Flush kills a store
    step(mk_sw(5'd1, 5'd2), 1'b1, "flush_sw", 0);
    check("flush_sw:mem_write", 64'(ex_mem_write), 64'd0);

    // Flush together with a load-use hazard
    step(mk_lw(5'd7, 5'd1), 1'b0, "lw7", 0);
    step(mk_add(5'd8, 5'd7, 5'd7), 1'b1, "flush_hz", 0);

    // Invalid slot masks X control
    nx = mk_add(5'd9, 5'd1, 5'd2);
    nx.valid = 1'b0; nx.reg_write = 1'bx;
    step(nx, 1'b0, "inv_x", 0);
    check("inv_x:reg_write", 64'(ex_reg_write), 64'd0);
    step(mk_lw(5'd4, 5'd1), 1'b0, "lw4", 0);
    nx = mk_add(5'd9, 5'd4, 5'd2);
    nx.valid = 1'b0;
    step(nx, 1'b0, "inv_dep", 0);

    // Back-to-back loads into the same rd, each followed by its consumer
    lw_i = mk_lw(5'd3, 5'd1);
    step(lw_i, 1'b0, "b2b_lw1", 0);
    lw_i = mk_lw(5'd3, 5'd3);
    step(lw_i, 1'b0, "b2b_lw2_stall", 1);
    step(lw_i, 1'b0, "b2b_lw2_go", 0);
    add_i = mk_add(5'd2, 5'd3, 5'd0);
    step(add_i, 1'b0, "b2b_use_stall", 1);
    step(add_i, 1'b0, "b2b_use_go", 0);

    // Randomized traffic; a stalled instruction is re-presented like real IF/ID
    nx = mk_rand();
    for (int n = 0; n < 400; n++) begin
      logic fl;
      logic stalled;
      fl = ($urandom_range(0, 7) == 0);
      stalled = model_hazard(nx) && !fl;
      step(nx, fl, "rand", -1);
      if (!stalled) nx = mk_rand();
    end

    // Asynchronous reset mid-stream
    step(mk_lw(5'd2, 5'd1), 1'b0, "pre_rst", 0);
    #2;
    rst_n = 1'b0;
    #1;
    m_ex = '0;
    exp_bubbles = 0;
    exp_flushes = 0;
    check_ex("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(mk_add(5'd1, 5'd2, 5'd3), 1'b0, "post_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
